tune_seq: RTL and testbench

TUNE_SEQ -- requirements
Module: tune_seq

---
 rtl/tune_seq.sv | 205 ++++++++++++++++++++
 tb/tb_tune_seq.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tune_seq.sv
// tune_seq: steps through a table of NUM_NOTES notes and plays each one as a
// square wave on pwm. Each note is a half-period (freq) and a length (dur, in
// ticks of clockSpeed clk cycles). A note with dur 0 is skipped. A note with
// freq 0 is a rest. The table is played repThreshold times, or until stop when
// loopMode is set. A pass in which no note was played ends the run.
module tune_seq #(
  parameter int NUM_NOTES = 8,
  parameter int FREQ_W    = 10,
  parameter int DUR_W     = 10,
  parameter int REP_W     = 8,
  parameter int DIV_W     = 32
) (
  input  logic                         clk,
  input  logic                         nReset,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         loopMode,
  input  logic [NUM_NOTES*FREQ_W-1:0]  freqs,
  input  logic [NUM_NOTES*DUR_W-1:0]   durs,
  input  logic [REP_W-1:0]             repThreshold,
  input  logic [DIV_W-1:0]             clockSpeed,
  output logic                         pwm,
  output logic                         makingMusic,
  output logic [$clog2(NUM_NOTES)-1:0] noteIdx,
  output logic                         done
);

  localparam int               IDX_W    = $clog2(NUM_NOTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NOTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    NEXT,
    PLAY,
    FINISH
  } state_t;

  state_t state;

  // Run configuration. It is captured at start so that later input changes
  // only affect the next run.
  logic [REP_W-1:0]  rep_thr;
  logic [DIV_W-1:0]  tick_div;

  // Pass bookkeeping.
  logic [REP_W-1:0]  rep_cnt;
  logic              any_played;

  // The current note. It is captured in NEXT so that the table may change
  // while the note plays.
  logic [FREQ_W-1:0] cur_freq;
  logic [DUR_W-1:0]  cur_dur;
  logic [FREQ_W-1:0] tone_cnt;
  logic [DIV_W-1:0]  tick_cnt;

  // Per-note views of the flat tables.
  logic [FREQ_W-1:0] freq_tab [NUM_NOTES];
  logic [DUR_W-1:0]  dur_tab  [NUM_NOTES];

  // Decode results.
  logic [FREQ_W-1:0] sel_freq;
  logic [DUR_W-1:0]  sel_dur;
  logic              last_note;
  logic              tone_hit;
  logic              tick_hit;
  logic              note_end;
  logic              advance;
  logic [REP_W:0]    rep_next;
  logic              pass_limit;
  logic              finish_now;
  logic [REP_W-1:0]  rep_cnt_inc;

  // Unpack the flat note tables into per-note fields.
  always_comb begin
    for (int i = 0; i < NUM_NOTES; i++) begin
      freq_tab[i] = freqs[i*FREQ_W +: FREQ_W];
      dur_tab[i]  = durs[i*DUR_W +: DUR_W];
    end
  end

  // Decode the selected note, the counter terminal counts and the advance decision.
  // NOTE: every signal here is assigned on every pass through the block, so no latch is inferred.
  always_comb begin
    sel_freq    = freq_tab[noteIdx];
    sel_dur     = dur_tab[noteIdx];
    last_note   = (noteIdx == LAST_IDX);
    tone_hit    = (cur_freq != '0) && (tone_cnt == cur_freq - FREQ_W'(1));
    tick_hit    = (tick_cnt == tick_div - DIV_W'(1));
    // cur_dur is never 0 in PLAY, so the tick that sees 1 is the last tick of the note.
    note_end    = tick_hit && (cur_dur == DUR_W'(1));
    advance     = ((state == NEXT) && (sel_dur == '0)) ||
                  ((state == PLAY) && note_end);
    // The compare is one bit wider, so a full rep_cnt cannot alias a small threshold.
    rep_next    = {1'b0, rep_cnt} + (REP_W+1)'(1);
    pass_limit  = !loopMode && (rep_next == {1'b0, rep_thr});
    // A pass that played nothing ends the run even in loop mode.
    finish_now  = last_note && (pass_limit || !any_played);
    // In loop mode rep_cnt saturates instead of wrapping.
    rep_cnt_inc = (&rep_cnt) ? rep_cnt : rep_next[REP_W-1:0];
  end

  // Sequencer FSM. It takes one edge per NEXT decision and one edge per PLAY
  // cycle. All outputs are registered here.
  // NOTE: all state uses non-blocking assignments, so every register reads its pre-edge value.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state       <= IDLE;
      rep_thr     <= '0;
      tick_div    <= '0;
      rep_cnt     <= '0;
      any_played  <= 1'b0;
      cur_freq    <= '0;
      cur_dur     <= '0;
      tone_cnt    <= '0;
      tick_cnt    <= '0;
      pwm         <= 1'b0;
      makingMusic <= 1'b0;
      noteIdx     <= '0;
      done        <= 1'b0;
    end else if (stop) begin
      // An abort from any state. It never produces a done pulse.
      state       <= IDLE;
      pwm         <= 1'b0;
      makingMusic <= 1'b0;
      noteIdx     <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            rep_thr     <= (repThreshold == '0) ? REP_W'(1) : repThreshold;
            tick_div    <= (clockSpeed == '0)   ? DIV_W'(1) : clockSpeed;
            noteIdx     <= '0;
            rep_cnt     <= '0;
            any_played  <= 1'b0;
            pwm         <= 1'b0;
            makingMusic <= 1'b1;
            state       <= NEXT;
          end
        end

        NEXT: begin
          // A zero-length note is handled by the advance path below.
          if (sel_dur != '0) begin
            cur_freq   <= sel_freq;
            cur_dur    <= sel_dur;
            tone_cnt   <= '0;
            tick_cnt   <= '0;
            pwm        <= 1'b0;
            any_played <= 1'b1;
            state      <= PLAY;
          end
        end

        PLAY: begin
          // Tone generator. pwm toggles every cur_freq cycles. A rest leaves pwm at 0.
          if (cur_freq != '0) begin
            if (tone_hit) begin
              pwm      <= ~pwm;
              tone_cnt <= '0;
            end else begin
              tone_cnt <= tone_cnt + FREQ_W'(1);
            end
          end
          // Duration ticks. The last tick is handled by the advance path below.
          if (tick_hit) begin
            tick_cnt <= '0;
            cur_dur  <= cur_dur - DUR_W'(1);
          end else begin
            tick_cnt <= tick_cnt + DIV_W'(1);
          end
        end

        FINISH: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase

      // Shared advance path for skipped notes and finished notes. These
      // assignments come after the case, so they override its pwm and state updates.
      if (advance) begin
        pwm     <= 1'b0;
        noteIdx <= last_note ? '0 : noteIdx + IDX_W'(1);
        if (last_note) begin
          rep_cnt    <= rep_cnt_inc;
          any_played <= 1'b0;
        end
        if (finish_now) begin
          state       <= FINISH;
          makingMusic <= 1'b0;
          done        <= 1'b1;
        end else begin
          state <= NEXT;
        end
      end
    end
  end

endmodule

// File: tb/tb_tune_seq.sv
// Bench for tune_seq (NUM_NOTES=4).
// A note-level behavioural model predicts pwm, makingMusic, noteIdx and done
// on every cycle. Directed scenarios also pin key timings to hand-computed values.
module tb_tune_seq;

  localparam int N  = 4;
  localparam int FW = 10;
  localparam int DW = 10;
  localparam int RW = 8;
  localparam int VW = 32;
  localparam int IW = $clog2(N);

  logic          clk;
  logic          nReset;
  logic          start;
  logic          stop;
  logic          loopMode;
  logic [N*FW-1:0] freqs;
  logic [N*DW-1:0] durs;
  logic [RW-1:0] repThreshold;
  logic [VW-1:0] clockSpeed;
  logic          pwm;
  logic          makingMusic;
  logic [IW-1:0] noteIdx;
  logic          done;

  tune_seq #(
    .NUM_NOTES(N),
    .FREQ_W   (FW),
    .DUR_W    (DW),
    .REP_W    (RW),
    .DIV_W    (VW)
  ) dut (
    .clk         (clk),
    .nReset      (nReset),
    .start       (start),
    .stop        (stop),
    .loopMode    (loopMode),
    .freqs       (freqs),
    .durs        (durs),
    .repThreshold(repThreshold),
    .clockSpeed  (clockSpeed),
    .pwm         (pwm),
    .makingMusic (makingMusic),
    .noteIdx     (noteIdx),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model tracks which note is sounding and how many PLAY cycles have
  // elapsed in it. pwm is derived arithmetically from the elapsed count.
  typedef enum {M_IDLE, M_NEXT, M_PLAY, M_FINISH} mphase_t;

  mphase_t m_phase = M_IDLE;
  int      m_idx   = 0;
  int      m_pass  = 0;
  int      m_thr   = 1;
  int      m_div   = 1;
  int      m_freq  = 0;
  int      m_len   = 0;
  int      m_k     = 0;
  bit      m_any   = 1'b0;
  bit      m_pwm   = 1'b0;
  bit      m_mm    = 1'b0;
  bit      m_done  = 1'b0;

  function automatic int note_freq(input int i);
    return int'(freqs[i*FW +: FW]);
  endfunction

  function automatic int note_dur(input int i);
    return int'(durs[i*DW +: DW]);
  endfunction

  task automatic m_advance();
    m_pwm = 1'b0;
    if (m_idx < N - 1) begin
      m_idx++;
      m_phase = M_NEXT;
    end else begin
      m_idx = 0;
      m_pass++;
      if ((!loopMode && m_pass == m_thr) || !m_any) begin
        m_phase = M_FINISH;
        m_mm    = 1'b0;
        m_done  = 1'b1;
      end else begin
        m_phase = M_NEXT;
      end
      m_any = 1'b0;
    end
  endtask

  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      m_phase = M_IDLE;
      m_idx   = 0;
      m_pass  = 0;
      m_any   = 1'b0;
      m_pwm   = 1'b0;
      m_mm    = 1'b0;
      m_done  = 1'b0;
    end else if (stop) begin
      m_phase = M_IDLE;
      m_idx   = 0;
      m_pwm   = 1'b0;
      m_mm    = 1'b0;
      m_done  = 1'b0;
    end else begin
      m_done = 1'b0;
      case (m_phase)
        M_IDLE: begin
          if (start) begin
            m_thr   = (repThreshold == 0) ? 1 : int'(repThreshold);
            m_div   = (clockSpeed == 0) ? 1 : int'(clockSpeed);
            m_idx   = 0;
            m_pass  = 0;
            m_any   = 1'b0;
            m_pwm   = 1'b0;
            m_mm    = 1'b1;
            m_phase = M_NEXT;
          end
        end
        M_NEXT: begin
          if (note_dur(m_idx) == 0) begin
            m_advance();
          end else begin
            m_freq  = note_freq(m_idx);
            m_len   = note_dur(m_idx) * m_div;
            m_k     = 0;
            m_any   = 1'b1;
            m_pwm   = 1'b0;
            m_phase = M_PLAY;
          end
        end
        M_PLAY: begin
          m_k++;
          if (m_k == m_len) m_advance();
          else m_pwm = (m_freq != 0) && (((m_k / m_freq) % 2) == 1);
        end
        M_FINISH: m_phase = M_IDLE;
        default:  m_phase = M_IDLE;
      endcase
    end
  end

  // Per-cycle compare, taken away from the active edge.
  always @(negedge clk) begin
    checks++;
    if (pwm !== m_pwm || makingMusic !== m_mm || noteIdx !== IW'(m_idx) || done !== m_done) begin
      errors++;
      $display("FAIL cycle @%0t: dut pwm=%b mm=%b idx=%0d done=%b, model pwm=%b mm=%b idx=%0d done=%b",
               $time, pwm, makingMusic, noteIdx, done, m_pwm, m_mm, m_idx, m_done);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load(input int f0, input int f1, input int f2, input int f3,
                      input int d0, input int d1, input int d2, input int d3,
                      input int rep, input int cs, input bit lp);
    freqs        = {FW'(f3), FW'(f2), FW'(f1), FW'(f0)};
    durs         = {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
    repThreshold = RW'(rep);
    clockSpeed   = VW'(cs);
    loopMode     = lp;
  endtask

  int o_done_cyc, o_done_cnt, o_pwm_edges, o_pwm_high_pre1, o_idx1_cyc, o_wraps, o_mm_high;

  // Call this at a negedge. It optionally pulses (or holds) start, then
  // observes the outputs for the given number of cycles. Cycle 0 is the first
  // negedge after the edge that sampled start.
  task automatic observe(input int cycles, input bit hold, input bit do_start);
    logic          prev_pwm;
    logic [IW-1:0] prev_idx;
    o_done_cyc = -1; o_done_cnt = 0; o_pwm_edges = 0; o_pwm_high_pre1 = 0;
    o_idx1_cyc = -1; o_wraps = 0; o_mm_high = 0;
    start = do_start;
    @(negedge clk);
    start = hold & do_start;
    prev_pwm = pwm;
    prev_idx = noteIdx;
    for (int c = 1; c <= cycles; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        o_done_cnt++;
        if (o_done_cyc < 0) begin
          o_done_cyc = c;
          start = 1'b0;
        end
      end
      if (pwm !== prev_pwm) o_pwm_edges++;
      if (o_idx1_cyc < 0) begin
        if (noteIdx == IW'(1)) o_idx1_cyc = c;
        else if (pwm === 1'b1) o_pwm_high_pre1++;
      end
      if (prev_idx == IW'(N - 1) && noteIdx == '0 && makingMusic === 1'b1) o_wraps++;
      if (makingMusic === 1'b1) o_mm_high++;
      prev_pwm = pwm;
      prev_idx = noteIdx;
    end
    start = 1'b0;
  endtask

  task automatic randomize_notes();
    for (int i = 0; i < N; i++) begin
      freqs[i*FW +: FW] = FW'($urandom_range(0, 5));
      durs[i*DW +: DW]  = DW'($urandom_range(0, 4));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    nReset = 1'b0; start = 1'b0; stop = 1'b0; loopMode = 1'b0;
    freqs = '0; durs = '0; repThreshold = '0; clockSpeed = '0;
    repeat (3) @(negedge clk);
    check("reset_pwm", pwm, 0);
    check("reset_mm", makingMusic, 0);
    check("reset_idx", noteIdx, 0);
    check("reset_done", done, 0);
    nReset = 1'b1;
    @(negedge clk);

    // Two passes of {7,12,1,7}/{15,0,5,15}. One pass takes 16+1+6+16 = 39 edges.
    load(7, 12, 1, 7, 15, 0, 5, 15, 2, 1, 1'b0);
    observe(90, 1'b0, 1'b1);
    check("A_done_cycle", o_done_cyc, 78);
    check("A_done_pulses", o_done_cnt, 1);
    check("A_pwm_edges", o_pwm_edges, 16);
    check("A_mm_after", makingMusic, 0);

    // Same run with start held high during playback. Timing must not change.
    observe(90, 1'b1, 1'b1);
    check("G_done_cycle", o_done_cyc, 78);
    check("G_done_pulses", o_done_cnt, 1);
    check("G_pwm_edges", o_pwm_edges, 16);

    // Rest note 0 of 3 ticks at clockSpeed 4: 1 NEXT edge + 12 silent PLAY edges.
    load(0, 3, 0, 0, 3, 2, 0, 0, 1, 4, 1'b0);
    observe(40, 1'b0, 1'b1);
    check("B_idx1_cycle", o_idx1_cyc, 13);
    check("B_pwm_high_in_rest", o_pwm_high_pre1, 0);
    check("B_done_cycle", o_done_cyc, 24);

    // All notes skipped, loop mode on: FINISH after 4 NEXT edges.
    load(5, 5, 5, 5, 0, 0, 0, 0, 0, 1, 1'b1);
    observe(10, 1'b0, 1'b1);
    check("C_done_cycle", o_done_cyc, 4);
    check("C_done_pulses", o_done_cnt, 1);

    // start and stop together in IDLE: the block stays idle.
    load(7, 12, 1, 7, 15, 0, 5, 15, 2, 1, 1'b0);
    start = 1'b1; stop = 1'b1;
    repeat (3) @(negedge clk);
    check("D_mm_idle", makingMusic, 0);
    start = 1'b0; stop = 1'b0;
    @(negedge clk);

    // Loop mode keeps wrapping (5 edges per pass). stop aborts without done.
    load(1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1'b1);
    observe(42, 1'b0, 1'b1);
    check("E_wraps", o_wraps, 8);
    check("E_no_done", o_done_cnt, 0);
    check("E_idx_before_stop", noteIdx, 1);
    stop = 1'b1;
    @(negedge clk);
    check("E_stop_mm", makingMusic, 0);
    check("E_stop_pwm", pwm, 0);
    check("E_stop_idx", noteIdx, 0);
    check("E_stop_done", done, 0);
    stop = 1'b0; loopMode = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-note, while pwm is high (note 0, PLAY cycle 9).
    load(7, 12, 1, 7, 15, 0, 5, 15, 2, 1, 1'b0);
    observe(10, 1'b1, 1'b1);
    start = 1'b0;
    check("F_pwm_before", pwm, 1);
    @(posedge clk);
    #2 nReset = 1'b0;
    #1;
    check("F_rst_pwm", pwm, 0);
    check("F_rst_mm", makingMusic, 0);
    check("F_rst_idx", noteIdx, 0);
    check("F_rst_done", done, 0);
    repeat (2) @(negedge clk);
    nReset = 1'b1;
    observe(20, 1'b0, 1'b0);
    check("F_no_done", o_done_cnt, 0);
    check("F_stays_idle", o_mm_high, 0);

    // Random traffic: table, configuration, start/stop, loop mode and resets.
    loopMode = 1'b0;
    for (int r = 0; r < 4000; r++) begin
      @(negedge clk);
      #2;
      if (!nReset) nReset = 1'b1;
      else if ($urandom_range(0, 499) == 0) nReset = 1'b0;
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) randomize_notes();
      if ($urandom_range(0, 15) == 0) begin
        repThreshold = RW'($urandom_range(0, 3));
        clockSpeed   = VW'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 199) == 0) loopMode = ~loopMode;
    end
    @(negedge clk);
    #2;
    start = 1'b0; stop = 1'b0; nReset = 1'b1; loopMode = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
